coin_credit_acc: RTL and testbench

Parametrised coin acceptor and credit accumulator for the vending datapath. It validates each inserted coin against three configurable denominations and accumulates accepted coins into a saturation-guarded credit register. It also deducts the price on a purchase request and, on cancel, returns the remaining credit as a greedy sequence of coins over a valid/ready handshake. It sits between the coin-slot front end and the product-dispense controller.

---
 rtl/coin_credit_acc.sv | 209 ++++++++++++++++++++
 tb/tb_coin_credit_acc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_acc.sv
// coin_credit_acc: coin acceptor and credit accumulator for the vending datapath.
// Validates coins against three denominations and keeps a saturation-guarded
// credit register. Purchases deduct the price. On cancel the credit is returned
// as a greedy sequence of coins over a valid/ready handshake.
module coin_credit_acc #(
    parameter int COIN_W     = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 99,
    parameter int DENOM_LO   = 1,
    parameter int DENOM_MID  = 5,
    parameter int DENOM_HI   = 10,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_strobe,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                buy_req,
    input  logic [CREDIT_W-1:0] price,
    input  logic                cancel,
    input  logic                refund_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                vend,
    output logic                buy_fail,
    output logic                refund_valid,
    output logic [COIN_W-1:0]   refund_coin,
    output logic                refund_done,
    output logic [CNT_W-1:0]    cnt_lo,
    output logic [CNT_W-1:0]    cnt_mid,
    output logic [CNT_W-1:0]    cnt_hi
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFUND = 1'b1
    } state_t;

    // Wide enough that credit + coin never wraps, whichever bus is wider.
    localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;

    localparam logic [COIN_W-1:0] LO_C  = COIN_W'(DENOM_LO);
    localparam logic [COIN_W-1:0] MID_C = COIN_W'(DENOM_MID);
    localparam logic [COIN_W-1:0] HI_C  = COIN_W'(DENOM_HI);
    localparam logic [SUM_W-1:0]  MAX_S = SUM_W'(MAX_CREDIT);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Largest denomination not exceeding the remaining credit (greedy refund).
    function automatic logic [COIN_W-1:0] pick_coin(input logic [CREDIT_W-1:0] cr);
        logic [SUM_W-1:0] cr_w;
        cr_w = SUM_W'(cr);
        if (cr_w >= SUM_W'(HI_C)) begin
            return HI_C;
        end else if (cr_w >= SUM_W'(MID_C)) begin
            return MID_C;
        end
        return LO_C;
    endfunction

    function automatic logic is_legal(input logic [COIN_W-1:0] v);
        return (v == LO_C) || (v == MID_C) || (v == HI_C);
    endfunction

    state_t                state_q,        state_d;
    logic [CREDIT_W-1:0]   credit_q,       credit_d;
    logic                  coin_accept_q,  coin_accept_d;
    logic                  coin_reject_q,  coin_reject_d;
    logic                  vend_q,         vend_d;
    logic                  buy_fail_q,     buy_fail_d;
    logic                  refund_valid_q, refund_valid_d;
    logic [COIN_W-1:0]     refund_coin_q,  refund_coin_d;
    logic                  refund_done_q,  refund_done_d;
    logic [CNT_W-1:0]      cnt_lo_q,       cnt_lo_d;
    logic [CNT_W-1:0]      cnt_mid_q,      cnt_mid_d;
    logic [CNT_W-1:0]      cnt_hi_q,       cnt_hi_d;

    logic [SUM_W-1:0]      coin_sum;
    logic [CREDIT_W-1:0]   refund_rem;

    assign coin_sum   = SUM_W'(credit_q) + SUM_W'(coin_value);
    assign refund_rem = credit_q - CREDIT_W'(refund_coin_q);

    // Next-state and next-output logic for both FSM states.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        coin_accept_d  = 1'b0;
        coin_reject_d  = 1'b0;
        vend_d         = 1'b0;
        buy_fail_d     = 1'b0;
        refund_valid_d = refund_valid_q;
        refund_coin_d  = refund_coin_q;
        refund_done_d  = 1'b0;
        cnt_lo_d       = cnt_lo_q;
        cnt_mid_d      = cnt_mid_q;
        cnt_hi_d       = cnt_hi_q;

        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    // Lower-priority requests in the same cycle are refused.
                    coin_reject_d = coin_strobe;
                    buy_fail_d    = buy_req;
                    if (credit_q == '0) begin
                        refund_done_d = 1'b1;
                    end else begin
                        state_d        = ST_REFUND;
                        refund_valid_d = 1'b1;
                        refund_coin_d  = pick_coin(credit_q);
                    end
                end else if (buy_req) begin
                    coin_reject_d = coin_strobe;
                    if (credit_q >= price) begin
                        credit_d = credit_q - price;
                        vend_d   = 1'b1;
                    end else begin
                        buy_fail_d = 1'b1;
                    end
                end else if (coin_strobe) begin
                    if (is_legal(coin_value) && (coin_sum <= MAX_S)) begin
                        credit_d      = coin_sum[CREDIT_W-1:0];
                        coin_accept_d = 1'b1;
                        if (coin_value == LO_C) begin
                            cnt_lo_d = sat_inc(cnt_lo_q);
                        end else if (coin_value == MID_C) begin
                            cnt_mid_d = sat_inc(cnt_mid_q);
                        end else begin
                            cnt_hi_d = sat_inc(cnt_hi_q);
                        end
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_REFUND: begin
                // While returning coins every new request is refused; cancel is moot.
                coin_reject_d = coin_strobe;
                buy_fail_d    = buy_req;
                if (refund_valid_q && refund_ready) begin
                    credit_d = refund_rem;
                    if (refund_rem == '0) begin
                        state_d        = ST_IDLE;
                        refund_valid_d = 1'b0;
                        refund_coin_d  = '0;
                        refund_done_d  = 1'b1;
                    end else begin
                        refund_coin_d = pick_coin(refund_rem);
                    end
                end
            end

            default: begin
                state_d        = ST_IDLE;
                refund_valid_d = 1'b0;
                refund_coin_d  = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            coin_accept_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_q         <= 1'b0;
            buy_fail_q     <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_coin_q  <= '0;
            refund_done_q  <= 1'b0;
            cnt_lo_q       <= '0;
            cnt_mid_q      <= '0;
            cnt_hi_q       <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            coin_accept_q  <= coin_accept_d;
            coin_reject_q  <= coin_reject_d;
            vend_q         <= vend_d;
            buy_fail_q     <= buy_fail_d;
            refund_valid_q <= refund_valid_d;
            refund_coin_q  <= refund_coin_d;
            refund_done_q  <= refund_done_d;
            cnt_lo_q       <= cnt_lo_d;
            cnt_mid_q      <= cnt_mid_d;
            cnt_hi_q       <= cnt_hi_d;
        end
    end

    assign credit       = credit_q;
    assign coin_accept  = coin_accept_q;
    assign coin_reject  = coin_reject_q;
    assign vend         = vend_q;
    assign buy_fail     = buy_fail_q;
    assign refund_valid = refund_valid_q;
    assign refund_coin  = refund_coin_q;
    assign refund_done  = refund_done_q;
    assign cnt_lo       = cnt_lo_q;
    assign cnt_mid      = cnt_mid_q;
    assign cnt_hi       = cnt_hi_q;

endmodule

// File: tb/tb_coin_credit_acc.sv
// Bench for coin_credit_acc: table of {inputs, expected outputs} vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_coin_credit_acc;

    logic       clk;
    logic       rst_n;
    logic       coin_strobe;
    logic [3:0] coin_value;
    logic       buy_req;
    logic [7:0] price;
    logic       cancel;
    logic       refund_ready;
    logic [7:0] credit;
    logic       coin_accept;
    logic       coin_reject;
    logic       vend;
    logic       buy_fail;
    logic       refund_valid;
    logic [3:0] refund_coin;
    logic       refund_done;
    logic [7:0] cnt_lo;
    logic [7:0] cnt_mid;
    logic [7:0] cnt_hi;

    coin_credit_acc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_strobe  (coin_strobe),
        .coin_value   (coin_value),
        .buy_req      (buy_req),
        .price        (price),
        .cancel       (cancel),
        .refund_ready (refund_ready),
        .credit       (credit),
        .coin_accept  (coin_accept),
        .coin_reject  (coin_reject),
        .vend         (vend),
        .buy_fail     (buy_fail),
        .refund_valid (refund_valid),
        .refund_coin  (refund_coin),
        .refund_done  (refund_done),
        .cnt_lo       (cnt_lo),
        .cnt_mid      (cnt_mid),
        .cnt_hi       (cnt_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {credit, accept, reject, vend, fail, rvalid, rcoin, rdone, lo, mid, hi}
    typedef struct {
        logic        strb;
        logic [3:0]  cv;
        logic        buy;
        logic [7:0]  pr;
        logic        cxl;
        logic        rdy;
        logic [41:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [41:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int strb, input int cv, input int buy, input int pr,
                                input int cxl, input int rdy, input int cr, input int acc,
                                input int rej, input int vnd, input int fl, input int rv,
                                input int rc, input int dn, input int lo, input int mid,
                                input int hi);
        vec_t v;
        v.strb = 1'(strb);
        v.cv   = 4'(cv);
        v.buy  = 1'(buy);
        v.pr   = 8'(pr);
        v.cxl  = 1'(cxl);
        v.rdy  = 1'(rdy);
        v.exp  = {8'(cr), 1'(acc), 1'(rej), 1'(vnd), 1'(fl), 1'(rv), 4'(rc), 1'(dn),
                  8'(lo), 8'(mid), 8'(hi)};
        return v;
    endfunction

    function automatic logic [41:0] dut_bundle();
        return {credit, coin_accept, coin_reject, vend, buy_fail, refund_valid,
                refund_coin, refund_done, cnt_lo, cnt_mid, cnt_hi};
    endfunction

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        coin_strobe  = 1'b0;
        coin_value   = '0;
        buy_req      = 1'b0;
        price        = '0;
        cancel       = 1'b0;
        refund_ready = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string name);
        sb_t e;
        coin_strobe  = v.strb;
        coin_value   = v.cv;
        buy_req      = v.buy;
        price        = v.pr;
        cancel       = v.cxl;
        refund_ready = v.rdy;
        sb.push_back('{name, v.exp});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got %h", name, dut_bundle());
        end else begin
            e = sb.pop_front();
            check(e.name, dut_bundle(), e.exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lo_exp;
        idle_inputs();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 check("reset_state", dut_bundle(), 42'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Coins, buys, rejects and a small refund of 4.
        //            strb cv buy pr cxl rdy  cr acc rej vnd fl rv rc dn lo mid hi
        tbl.push_back(mk(1,  5, 0,  0, 0, 1,   5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 10, 0,  0, 0, 1,  15, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,  1, 0,  0, 0, 1,  16, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 1, 12, 0, 1,   4, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 1,  5, 0, 1,   4, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 1,  0, 0, 1,   4, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1,  5, 1,  0, 0, 1,   4, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1,  3, 0,  0, 0, 1,   4, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1,  0, 0,  0, 0, 1,   4, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 15, 0,  0, 0, 1,   4, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1,  1, 1,  0, 1, 0,   4, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 0,  0, 0, 1,   3, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 0,  0, 0, 1,   2, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 0,  0, 0, 1,   1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Climb to 95, then probe the MAX_CREDIT boundary.
        for (int i = 1; i <= 9; i++) begin
            apply(mk(1, 10, 0, 0, 0, 1, 10 * i, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1 + i),
                  $sformatf("climb%0d", i));
        end
        apply(mk(1,  5, 0,  0, 0, 1, 95, 1, 0, 0, 0, 0, 0, 0, 1, 2, 10), "ovf_to95");
        apply(mk(1, 10, 0,  0, 0, 1, 95, 0, 1, 0, 0, 0, 0, 0, 1, 2, 10), "ovf_rej10");
        apply(mk(1,  1, 0,  0, 0, 1, 96, 1, 0, 0, 0, 0, 0, 0, 2, 2, 10), "ovf_to96");
        apply(mk(1,  5, 0,  0, 0, 1, 96, 0, 1, 0, 0, 0, 0, 0, 2, 2, 10), "ovf_rej5");
        apply(mk(1,  1, 0,  0, 0, 1, 97, 1, 0, 0, 0, 0, 0, 0, 3, 2, 10), "ovf_to97");
        apply(mk(1,  1, 0,  0, 0, 1, 98, 1, 0, 0, 0, 0, 0, 0, 4, 2, 10), "ovf_to98");
        apply(mk(1,  1, 0,  0, 0, 1, 99, 1, 0, 0, 0, 0, 0, 0, 5, 2, 10), "ovf_to99");
        apply(mk(1,  1, 0,  0, 0, 1, 99, 0, 1, 0, 0, 0, 0, 0, 5, 2, 10), "ovf_rej100");
        apply(mk(0,  0, 1, 99, 0, 1,  0, 0, 0, 1, 0, 0, 0, 0, 5, 2, 10), "buy_exact");

        // Refund of 17 with ready held high; a repeated cancel is ignored.
        apply(mk(1, 10, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0,  0, 0, 5, 2, 11), "r17_c10");
        apply(mk(1,  5, 0, 0, 0, 1, 15, 1, 0, 0, 0, 0,  0, 0, 5, 3, 11), "r17_c5");
        apply(mk(1,  1, 0, 0, 0, 1, 16, 1, 0, 0, 0, 0,  0, 0, 6, 3, 11), "r17_c1a");
        apply(mk(1,  1, 0, 0, 0, 1, 17, 1, 0, 0, 0, 0,  0, 0, 7, 3, 11), "r17_c1b");
        apply(mk(0,  0, 0, 0, 1, 1, 17, 0, 0, 0, 0, 1, 10, 0, 7, 3, 11), "r17_cancel");
        apply(mk(0,  0, 0, 0, 1, 1,  7, 0, 0, 0, 0, 1,  5, 0, 7, 3, 11), "r17_out10");
        apply(mk(0,  0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 1,  1, 0, 7, 3, 11), "r17_out5");
        apply(mk(0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1,  1, 0, 7, 3, 11), "r17_out1a");
        apply(mk(0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0,  0, 1, 7, 3, 11), "r17_done");

        // Refund of 6 under backpressure, with busy-time coin and buy refused.
        apply(mk(1,  5, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 7, 4, 11), "bp_c5");
        apply(mk(1,  1, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 8, 4, 11), "bp_c1");
        apply(mk(0,  0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 1, 5, 0, 8, 4, 11), "bp_cancel");
        apply(mk(0,  0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1, 5, 0, 8, 4, 11), "bp_hold1");
        apply(mk(1, 10, 0, 0, 0, 0, 6, 0, 1, 0, 0, 1, 5, 0, 8, 4, 11), "bp_hold_coin");
        apply(mk(0,  0, 1, 0, 0, 0, 6, 0, 0, 0, 1, 1, 5, 0, 8, 4, 11), "bp_hold_buy");
        apply(mk(0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 8, 4, 11), "bp_out5");
        apply(mk(0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 8, 4, 11), "bp_done");

        // Reset in the middle of refunding 23.
        apply(mk(1, 10, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0,  0, 0,  8, 4, 12), "rr_c10a");
        apply(mk(1, 10, 0, 0, 0, 1, 20, 1, 0, 0, 0, 0,  0, 0,  8, 4, 13), "rr_c10b");
        apply(mk(1,  1, 0, 0, 0, 1, 21, 1, 0, 0, 0, 0,  0, 0,  9, 4, 13), "rr_c1a");
        apply(mk(1,  1, 0, 0, 0, 1, 22, 1, 0, 0, 0, 0,  0, 0, 10, 4, 13), "rr_c1b");
        apply(mk(1,  1, 0, 0, 0, 1, 23, 1, 0, 0, 0, 0,  0, 0, 11, 4, 13), "rr_c1c");
        apply(mk(0,  0, 0, 0, 1, 0, 23, 0, 0, 0, 0, 1, 10, 0, 11, 4, 13), "rr_cancel");
        apply(mk(0,  0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 1, 10, 0, 11, 4, 13), "rr_out10");
        rst_n = 1'b0;
        #1 check("reset_mid_refund", dut_bundle(), 42'h0);
        idle_inputs();
        @(posedge clk);
        #1 check("reset_held", dut_bundle(), 42'h0);
        @(negedge clk) rst_n = 1'b1;

        // Cancel with zero credit: immediate refund_done, no refund_valid.
        apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "zero_cancel");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "zero_after");

        // Drive cnt_lo past all-ones and confirm it saturates.
        for (int i = 0; i < 260; i++) begin
            lo_exp = (i + 1 > 255) ? 255 : i + 1;
            apply(mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, lo_exp, 0, 0),
                  $sformatf("sat_coin%0d", i));
            apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, lo_exp, 0, 0),
                  $sformatf("sat_buy%0d", i));
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
